// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem over req/ack,
// and feeds {pc, pc+4, instr} into the IF/ID register, holding words across stalls.
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic              valid_o,
  output logic              flush_o
);

  // Handshake: imem_req_o/imem_addr_o stay stable until the cycle imem_ack_i=1;
  // imem_data_i is only meaningful in that cycle. An instruction moves into IF/ID
  // on an edge where valid_o=1 and stall_i=0, unless flush_o zeroes IF/ID instead.

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t              state_q;
  logic [ADDR_W-1:0]   fetch_pc_q;
  logic [DATA_W-1:0]   hold_instr_q;
  logic [ADDR_W-1:0]   hold_pc_q;
  logic                hold_valid_q;
  logic [ADDR_W-1:0]   redir_pc_q;

  logic [ADDR_W-1:0]   redir_tgt;
  logic                fetch_done;
  logic                unused_low_bits;

  assign redir_tgt       = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign unused_low_bits = ^redirect_pc_i[1:0];
  assign fetch_done      = (state_q == ST_FETCH) && imem_ack_i;

  assign imem_req_o  = !rst_i && (state_q != ST_HOLD);
  assign imem_addr_o = fetch_pc_q;
  assign flush_o     = redirect_i;

  // Held word wins; otherwise the returning word bypasses straight to IF/ID.
  always_comb begin
    valid_o    = 1'b0;
    instr_o    = '0;
    pc_o       = '0;
    pc_plus4_o = '0;
    if (hold_valid_q) begin
      valid_o    = 1'b1;
      instr_o    = hold_instr_q;
      pc_o       = hold_pc_q;
      pc_plus4_o = hold_pc_q + PC_STEP;
    end else if (fetch_done) begin
      valid_o    = 1'b1;
      instr_o    = imem_data_i;
      pc_o       = fetch_pc_q;
      pc_plus4_o = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_FETCH;
      fetch_pc_q   <= RESET_PC;
      hold_valid_q <= 1'b0;
      redir_pc_q   <= '0;
    end else if (redirect_i) begin
      hold_valid_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (imem_ack_i) begin
            fetch_pc_q <= redir_tgt;
          end else begin
            // Access still in flight: finish it before refetching at the target.
            redir_pc_q <= redir_tgt;
            state_q    <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          fetch_pc_q <= redir_tgt;
          state_q    <= ST_FETCH;
        end
        default: begin
          redir_pc_q <= redir_tgt;
          state_q    <= ST_DRAIN;
        end
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack_i) begin
            if (stall_i) begin
              hold_instr_q <= imem_data_i;
              hold_pc_q    <= fetch_pc_q;
              hold_valid_q <= 1'b1;
              state_q      <= ST_HOLD;
            end else begin
              fetch_pc_q <= fetch_pc_q + PC_STEP;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            hold_valid_q <= 1'b0;
            fetch_pc_q   <= hold_pc_q + PC_STEP;
            state_q      <= ST_FETCH;
          end
        end
        default: begin
          if (imem_ack_i) begin
            fetch_pc_q <= redir_pc_q;
            state_q    <= ST_FETCH;
          end
        end
      endcase
    end
  end

endmodule
